// File: rtl/uart_lite_axi_regs.sv
// uart_lite_axi_regs
// AXI4-Lite register block for a UART-Lite. It holds the RX FIFO, TX FIFO,
// STAT and CTRL registers and moves bytes between the bus and the serial cores.
//
// Ports
//   s_axi_aclk, s_axi_areset     clock, synchronous active-high reset
//   s_axi_aw*/w*/b*              AXI4-Lite write address / data / response
//   s_axi_ar*/r*                 AXI4-Lite read address / data
//   tx_data, tx_valid, tx_ready  TX FIFO head byte stream to the TX shifter
//   rx_data, rx_valid            byte strobe from the RX sampler (no backpressure)
//   rx_frame_err, rx_parity_err  error strobes from the RX sampler
//   interrupt                    one-cycle pulse on RX empty->non-empty or TX non-empty->empty
//
// Register map (addr[3:2]): 0 RX_FIFO (RO, pops), 1 TX_FIFO (WO, pushes),
// 2 STAT (RO, clears sticky [7:5]), 3 CTRL (WO: [0] flush TX, [1] flush RX, [4] intr_en).
module uart_lite_axi_regs #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 13
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_areset,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_frame_err,
    input  logic              rx_parity_err,
    output logic              interrupt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] PTR_ZERO = (AW+1)'(0);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] REG_RX   = 2'd0;
    localparam logic [1:0] REG_TX   = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    w_state_t    w_state_r;
    logic        awready_r, wready_r, bvalid_r;
    logic [1:0]  bresp_r;
    r_state_t    r_state_r;
    logic        arready_r, rvalid_r;
    logic [31:0] rdata_r;
    logic [1:0]  rresp_r;

    logic [7:0]  rx_mem_r [FIFO_DEPTH];
    logic [AW:0] rx_wr_ptr_r, rx_rd_ptr_r;
    logic [7:0]  tx_mem_r [FIFO_DEPTH];
    logic [AW:0] tx_wr_ptr_r, tx_rd_ptr_r;
    logic [AW:0] tx_wr_ptr_nxt_s, tx_rd_ptr_nxt_s;
    logic        tx_valid_r;
    logic [7:0]  tx_data_r;

    logic        intr_en_r, overrun_r, frame_err_r, parity_err_r;
    logic        rx_empty_d_r, tx_empty_d_r, interrupt_r;

    logic        wr_hs_s, rd_hs_s, wr_bad_s, ctrl_wr_s;
    logic [1:0]  wr_sel_s, rd_sel_s;
    logic        rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
    logic        rx_push_s, rx_pop_s, rx_flush_s, overrun_set_s;
    logic        tx_push_s, tx_pop_s, tx_flush_s, tx_bypass_s;
    logic        stat_clr_s;
    logic [31:0] stat_s, rd_data_s;
    logic [1:0]  rd_resp_s;
    logic        unused_s;

    assign unused_s = ^{s_axi_awaddr[ADDR_W-1:4], s_axi_awaddr[1:0],
                        s_axi_araddr[ADDR_W-1:4], s_axi_araddr[1:0],
                        s_axi_wdata[31:8], s_axi_wstrb[3:1]};

    // Handshakes complete in the cycle the registered ready is high.
    assign wr_hs_s  = (w_state_r == W_IDLE) && awready_r && s_axi_awvalid && s_axi_wvalid;
    assign rd_hs_s  = (r_state_r == R_IDLE) && arready_r && s_axi_arvalid;
    assign wr_sel_s = s_axi_awaddr[3:2];
    assign rd_sel_s = s_axi_araddr[3:2];
    assign wr_bad_s = (wr_sel_s == REG_RX) || (wr_sel_s == REG_STAT);

    assign ctrl_wr_s  = wr_hs_s && (wr_sel_s == REG_CTRL) && s_axi_wstrb[0];
    assign tx_flush_s = ctrl_wr_s && s_axi_wdata[0];
    assign rx_flush_s = ctrl_wr_s && s_axi_wdata[1];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign rx_empty_s = (rx_wr_ptr_r == rx_rd_ptr_r);
    assign rx_full_s  = ((rx_wr_ptr_r - rx_rd_ptr_r) == DEPTH_C);
    assign tx_empty_s = (tx_wr_ptr_r == tx_rd_ptr_r);
    assign tx_full_s  = ((tx_wr_ptr_r - tx_rd_ptr_r) == DEPTH_C);

    // A pop frees a slot in the same cycle, so a full FIFO may still accept a push.
    assign rx_pop_s      = rd_hs_s && (rd_sel_s == REG_RX) && !rx_empty_s;
    assign rx_push_s     = rx_valid && (!rx_full_s || rx_pop_s);
    assign overrun_set_s = rx_valid && rx_full_s && !rx_pop_s;
    assign tx_pop_s      = tx_valid_r && tx_ready;
    assign tx_push_s     = wr_hs_s && (wr_sel_s == REG_TX) && s_axi_wstrb[0] && (!tx_full_s || tx_pop_s);
    assign stat_clr_s    = rd_hs_s && (rd_sel_s == REG_STAT);

    assign stat_s = {24'h000000, parity_err_r, frame_err_r, overrun_r, intr_en_r,
                     tx_full_s, tx_empty_s, rx_full_s, !rx_empty_s};

    // Read data/response selection for the address on the AR channel.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        rd_resp_s = RESP_OKAY;
        case (rd_sel_s)
            REG_RX: begin
                if (rx_empty_s) begin
                    rd_data_s = 32'h0000_0000;
                end else begin
                    rd_data_s = {24'h000000, rx_mem_r[rx_rd_ptr_r[AW-1:0]]};
                end
            end
            REG_STAT: rd_data_s = stat_s;
            REG_TX, REG_CTRL: rd_resp_s = RESP_SLVERR;
            default: begin
                rd_data_s = 32'h0000_0000;
                rd_resp_s = RESP_SLVERR;
            end
        endcase
    end

    // Write channel FSM: accept AW and W together, then hold B until bready.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (awready_r) begin
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                        if (wr_hs_s) begin
                            bvalid_r  <= 1'b1;
                            bresp_r   <= wr_bad_s ? RESP_SLVERR : RESP_OKAY;
                            w_state_r <= W_RESP;
                        end
                    end else if (s_axi_awvalid && s_axi_wvalid) begin
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_r  <= 1'b0;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                    awready_r <= 1'b0;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read channel FSM: capture data at the AR handshake, hold R until rready.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0000_0000;
            rresp_r   <= RESP_OKAY;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (arready_r) begin
                        arready_r <= 1'b0;
                        if (rd_hs_s) begin
                            rvalid_r  <= 1'b1;
                            rdata_r   <= rd_data_s;
                            rresp_r   <= rd_resp_s;
                            r_state_r <= R_DATA;
                        end
                    end else if (s_axi_arvalid) begin
                        arready_r <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        rvalid_r  <= 1'b0;
                        r_state_r <= R_IDLE;
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    arready_r <= 1'b0;
                    rvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    // RX FIFO storage.
    always_ff @(posedge s_axi_aclk) begin
        if (rx_push_s && !rx_flush_s) begin
            rx_mem_r[rx_wr_ptr_r[AW-1:0]] <= rx_data;
        end
    end

    // RX FIFO pointers; a flush overrides any push or pop in the same cycle.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset || rx_flush_s) begin
            rx_wr_ptr_r <= PTR_ZERO;
            rx_rd_ptr_r <= PTR_ZERO;
        end else begin
            if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
            if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
        end
    end

    // TX FIFO next-pointer computation, shared by pointers and registered head.
    always_comb begin
        tx_wr_ptr_nxt_s = tx_wr_ptr_r;
        tx_rd_ptr_nxt_s = tx_rd_ptr_r;
        if (tx_flush_s) begin
            tx_wr_ptr_nxt_s = PTR_ZERO;
            tx_rd_ptr_nxt_s = PTR_ZERO;
        end else begin
            if (tx_push_s) begin
                tx_wr_ptr_nxt_s = tx_wr_ptr_r + PTR_ONE;
            end else begin
                tx_wr_ptr_nxt_s = tx_wr_ptr_r;
            end
            if (tx_pop_s) begin
                tx_rd_ptr_nxt_s = tx_rd_ptr_r + PTR_ONE;
            end else begin
                tx_rd_ptr_nxt_s = tx_rd_ptr_r;
            end
        end
    end

    // A byte pushed into the slot that becomes the head bypasses the array.
    assign tx_bypass_s = tx_push_s && !tx_flush_s &&
                         (tx_wr_ptr_r[AW-1:0] == tx_rd_ptr_nxt_s[AW-1:0]);

    // TX FIFO storage.
    always_ff @(posedge s_axi_aclk) begin
        if (tx_push_s && !tx_flush_s) begin
            tx_mem_r[tx_wr_ptr_r[AW-1:0]] <= s_axi_wdata[7:0];
        end
    end

    // TX FIFO pointers and the registered head presented to the shifter.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            tx_wr_ptr_r <= PTR_ZERO;
            tx_rd_ptr_r <= PTR_ZERO;
            tx_valid_r  <= 1'b0;
            tx_data_r   <= 8'h00;
        end else begin
            tx_wr_ptr_r <= tx_wr_ptr_nxt_s;
            tx_rd_ptr_r <= tx_rd_ptr_nxt_s;
            tx_valid_r  <= (tx_wr_ptr_nxt_s != tx_rd_ptr_nxt_s);
            tx_data_r   <= tx_bypass_s ? s_axi_wdata[7:0] : tx_mem_r[tx_rd_ptr_nxt_s[AW-1:0]];
        end
    end

    // Control and sticky status; a new error in the clearing cycle is kept.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            intr_en_r    <= 1'b0;
            overrun_r    <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            if (ctrl_wr_s) intr_en_r <= s_axi_wdata[4];
            overrun_r    <= (overrun_r    && !stat_clr_s) || overrun_set_s;
            frame_err_r  <= (frame_err_r  && !stat_clr_s) || rx_frame_err;
            parity_err_r <= (parity_err_r && !stat_clr_s) || rx_parity_err;
        end
    end

    // Interrupt pulse on RX becoming non-empty or TX becoming empty.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            rx_empty_d_r <= 1'b1;
            tx_empty_d_r <= 1'b1;
            interrupt_r  <= 1'b0;
        end else begin
            rx_empty_d_r <= rx_empty_s;
            tx_empty_d_r <= tx_empty_s;
            interrupt_r  <= intr_en_r && ((rx_empty_d_r && !rx_empty_s) ||
                                          (!tx_empty_d_r && tx_empty_s));
        end
    end

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = wready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = rresp_r;
    assign tx_valid      = tx_valid_r;
    assign tx_data       = tx_data_r;
    assign interrupt     = interrupt_r;

endmodule

// File: tb/tb_uart_lite_axi_regs.sv
// Self-checking bench for uart_lite_axi_regs: a vector table of register
// accesses plus hand-written sequences for FIFO, interrupt and handshake corners.
// Expected responses go into a scoreboard queue when a transaction is driven
// and are popped when the DUT answers.
module tb_uart_lite_axi_regs;

    logic        clk = 1'b0;
    logic        areset;
    logic [12:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_frame_err, rx_parity_err, interrupt;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        is_wr;
        logic [12:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;
    vec_t vecs[12];

    uart_lite_axi_regs #(.FIFO_DEPTH(16), .ADDR_W(13)) dut (
        .s_axi_aclk(clk), .s_axi_areset(areset),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
        .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no handshake, want one within 20 cycles", name);
    endtask

    // Compare one DUT response against the oldest scoreboard entry.
    task automatic sb_compare(input string name, input logic [31:0] data, input logic [1:0] resp,
                              input logic cmp_data);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({name, " scoreboard"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            if (cmp_data) check({name, " data"}, 64'(data), 64'(e.data));
            check({name, " resp"}, 64'(resp), 64'(e.resp));
        end
    endtask

    task automatic axi_write(input string name, input logic [12:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] exp_resp);
        exp_exp: begin
            exp_q.push_back({32'h0, exp_resp});
        end
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        for (int c = 0; c < 20 && !awready; c++) @(negedge clk);
        if (!awready) begin
            expire({name, " aw"});
            awvalid = 1'b0; wvalid = 1'b0;
            void'(exp_q.pop_back());
        end else begin
            @(negedge clk);
            awvalid = 1'b0; wvalid = 1'b0;
            for (int c = 0; c < 20 && !bvalid; c++) @(negedge clk);
            if (bvalid) begin
                sb_compare(name, 32'h0, bresp, 1'b0);
                @(negedge clk);
            end else begin
                expire({name, " b"});
                void'(exp_q.pop_back());
            end
        end
    endtask

    task automatic axi_read(input string name, input logic [12:0] a, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        exp_q.push_back({exp_data, exp_resp});
        araddr = a; arvalid = 1'b1;
        for (int c = 0; c < 20 && !arready; c++) @(negedge clk);
        if (!arready) begin
            expire({name, " ar"});
            arvalid = 1'b0;
            void'(exp_q.pop_back());
        end else begin
            @(negedge clk);
            arvalid = 1'b0;
            for (int c = 0; c < 20 && !rvalid; c++) @(negedge clk);
            if (rvalid) begin
                sb_compare(name, rdata, rresp, 1'b1);
                @(negedge clk);
            end else begin
                expire({name, " r"});
                void'(exp_q.pop_back());
            end
        end
    endtask

    // Count interrupt pulses over six negedges, recording where the first one appears.
    task automatic watch_irq(input string name);
        int n;
        int first;
        n = 0;
        first = 0;
        for (int k = 1; k <= 6; k++) begin
            if (interrupt) begin
                n++;
                if (first == 0) first = k;
            end
            @(negedge clk);
        end
        check({name, " irq count"}, 64'(n), 64'd1);
        check({name, " irq time"}, 64'(first), 64'd2);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 13'h0008, 32'h0000_0000, 4'h0, 32'h0000_0004, 2'b00};
        vecs[1]  = '{1'b1, 13'h0004, 32'h0000_0041, 4'h1, 32'h0000_0000, 2'b00};
        vecs[2]  = '{1'b0, 13'h0008, 32'h0000_0000, 4'h0, 32'h0000_0000, 2'b00};
        vecs[3]  = '{1'b1, 13'h0000, 32'h0000_0012, 4'hF, 32'h0000_0000, 2'b10};
        vecs[4]  = '{1'b0, 13'h000C, 32'h0000_0000, 4'h0, 32'h0000_0000, 2'b10};
        vecs[5]  = '{1'b0, 13'h0004, 32'h0000_0000, 4'h0, 32'h0000_0000, 2'b10};
        vecs[6]  = '{1'b1, 13'h0008, 32'h0000_00FF, 4'hF, 32'h0000_0000, 2'b10};
        vecs[7]  = '{1'b0, 13'h0000, 32'h0000_0000, 4'h0, 32'h0000_0000, 2'b00};
        vecs[8]  = '{1'b1, 13'h0004, 32'h0000_0099, 4'h2, 32'h0000_0000, 2'b00};
        vecs[9]  = '{1'b1, 13'h000C, 32'h0000_0013, 4'h0, 32'h0000_0000, 2'b00};
        vecs[10] = '{1'b0, 13'h0008, 32'h0000_0000, 4'h0, 32'h0000_0000, 2'b00};
        vecs[11] = '{1'b0, 13'h1008, 32'h0000_0000, 4'h0, 32'h0000_0000, 2'b00};

        areset = 1'b1;
        awaddr = 13'h0; araddr = 13'h0; wdata = 32'h0; wstrb = 4'h0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        rx_frame_err = 1'b0; rx_parity_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs",
              64'({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, tx_valid, interrupt}),
              64'd0);
        areset = 1'b0;
        @(negedge clk);

        // Register map vectors.
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_wr) begin
                axi_write($sformatf("vec%0d wr", i), vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                          vecs[i].exp_resp);
            end else begin
                axi_read($sformatf("vec%0d rd", i), vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
            end
        end
        check("tx head after push", 64'({tx_valid, tx_data}), 64'h141);

        // RX overrun: 17 strobes into a 16-entry FIFO.
        for (int i = 0; i <= 16; i++) begin
            rx_data = 8'(i); rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        axi_read("stat overrun", 13'h8, 32'h23, 2'b00);
        axi_read("stat cleared", 13'h8, 32'h03, 2'b00);
        for (int i = 0; i < 16; i++) axi_read($sformatf("rx pop %0d", i), 13'h0, 32'(i), 2'b00);
        axi_read("rx pop empty", 13'h0, 32'h0, 2'b00);

        // Interrupt on RX empty -> non-empty.
        axi_write("ctrl intr_en", 13'hC, 32'h10, 4'h1, 2'b00);
        rx_data = 8'h55; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        watch_irq("rx");

        // Sticky frame/parity errors.
        rx_frame_err = 1'b1; rx_parity_err = 1'b1;
        @(negedge clk);
        rx_frame_err = 1'b0; rx_parity_err = 1'b0;
        axi_read("stat errs", 13'h8, 32'hD1, 2'b00);
        axi_read("stat errs clr", 13'h8, 32'h11, 2'b00);
        axi_read("rx 0x55", 13'h0, 32'h55, 2'b00);

        // Interrupt on TX non-empty -> empty.
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check("tx drained", 64'(tx_valid), 64'd0);
        watch_irq("tx");

        // TX fill to full, overflow dropped, drain in order.
        for (int i = 0; i < 16; i++) axi_write($sformatf("tx push %0d", i), 13'h4, 32'(i), 4'h1, 2'b00);
        axi_read("stat tx full", 13'h8, 32'h18, 2'b00);
        axi_write("tx push full", 13'h4, 32'h77, 4'h1, 2'b00);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("tx drain %0d", i), 64'({tx_valid, tx_data}), 64'({1'b1, 8'(i)}));
            @(negedge clk);
        end
        tx_ready = 1'b0;
        check("tx drop on full", 64'(tx_valid), 64'd0);

        // Flush both FIFOs.
        axi_write("tx push a1", 13'h4, 32'hA1, 4'h1, 2'b00);
        axi_write("tx push a2", 13'h4, 32'hA2, 4'h1, 2'b00);
        rx_data = 8'h31; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        axi_write("ctrl flush", 13'hC, 32'h13, 4'h1, 2'b00);
        check("tx flushed", 64'(tx_valid), 64'd0);
        axi_read("stat flushed", 13'h8, 32'h14, 2'b00);
        axi_read("rx flushed", 13'h0, 32'h0, 2'b00);

        // awvalid ahead of wvalid; B held with bready low; no second write taken.
        bready = 1'b0;
        awaddr = 13'h4; wdata = 32'h5A; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("aw alone %0d", k), 64'(awready), 64'd0);
        end
        wvalid = 1'b1;
        exp_q.push_back({32'h0, 2'b00});
        for (int c = 0; c < 20 && !awready; c++) @(negedge clk);
        if (!awready) begin
            expire("early aw");
            void'(exp_q.pop_back());
        end
        @(negedge clk);
        wdata = 32'hA5;
        check("bvalid hold 1", 64'({bvalid, awready}), 64'h2);
        @(negedge clk);
        check("bvalid hold 2", 64'({bvalid, awready}), 64'h2);
        awvalid = 1'b0; wvalid = 1'b0;
        if (bvalid) sb_compare("early aw b", 32'h0, bresp, 1'b0);
        bready = 1'b1;
        @(negedge clk);
        check("bvalid released", 64'(bvalid), 64'd0);
        check("single write head", 64'({tx_valid, tx_data}), 64'h15A);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check("single write only", 64'(tx_valid), 64'd0);

        // Reset while R is waiting for rready.
        rready = 1'b0;
        araddr = 13'h8; arvalid = 1'b1;
        for (int c = 0; c < 20 && !arready; c++) @(negedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        for (int c = 0; c < 20 && !rvalid; c++) @(negedge clk);
        check("r pending", 64'({rvalid, rdata}), 64'({1'b1, 32'h14}));
        areset = 1'b1;
        @(negedge clk);
        check("rvalid dropped by reset", 64'(rvalid), 64'd0);
        areset = 1'b0;
        rready = 1'b1;
        @(negedge clk);
        axi_read("stat after reset", 13'h8, 32'h04, 2'b00);

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
